// File: rtl/dsi_lane_receiver_if.sv
// Aligned payload bus from the lane receiver toward the RX lane-merge FIFO.
interface dsi_lane_receiver_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_sot;
  logic       rx_eot;
  logic       rx_active;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_sot,
    output rx_eot,
    output rx_active
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input rx_sot,
    input rx_eot,
    input rx_active
  );
endinterface

// File: rtl/dsi_lane_receiver.sv
// Single-lane D-PHY receiver: LP entry sequencing, HS sync-byte search at any
// bit offset, and aligned payload delivery with the HS trailer stripped.
module dsi_lane_receiver #(
  parameter int unsigned HS_SETTLE_CYCLES = 4,
  parameter int unsigned SYNC_TIMEOUT     = 32,
  parameter int unsigned TRAIL_BYTES      = 4
) (
  input  logic                       clk_sys,
  input  logic                       rst_n,
  input  logic                       lines_enable,
  input  logic                       LP_p_input,
  input  logic                       LP_n_input,
  input  logic [7:0]                 hs_input,
  output logic                       hs_term_enable,
  output logic                       stop_state,
  output logic                       err_sot,
  output logic                       err_control,
  dsi_lane_receiver_if.master        rx
);

  localparam int unsigned CNT_W     = 8;
  localparam logic [7:0]  SYNC_BYTE = 8'hB8;
  localparam logic [1:0]  LP_00     = 2'b00;
  localparam logic [1:0]  LP_01     = 2'b01;
  localparam logic [1:0]  LP_10     = 2'b10;
  localparam logic [1:0]  LP_11     = 2'b11;

  typedef enum logic [2:0] {
    ST_DISABLED,
    ST_WAIT_STOP,
    ST_STOP,
    ST_HS_RQST,
    ST_HS_SETTLE,
    ST_SYNC_SEARCH,
    ST_HS_DATA
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         offset_q, offset_d;
  logic [1:0]         lp_meta_q, lp_sync_q;
  logic [7:0]         hs_prev_q;
  logic [15:0]        window_c;
  logic               match_c;
  logic [2:0]         match_k_c;
  logic [7:0]         byte_c;
  logic               push_c, flush_c;
  logic               rx_eot_d, err_sot_d, err_control_d;
  logic               term_d, stop_d, active_d;
  logic               out_valid_c;
  logic               sent_q;

  logic [7:0]             dl_data_q [TRAIL_BYTES];
  logic [TRAIL_BYTES-1:0] dl_valid_q;

  logic       term_q, stop_q, err_sot_q, err_control_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q, rx_sot_q, rx_eot_q, rx_active_q;

  // Two-flop synchronizer for the asynchronous LP line levels.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      lp_meta_q <= '0;
      lp_sync_q <= '0;
    end else begin
      lp_meta_q <= {LP_p_input, LP_n_input};
      lp_sync_q <= lp_meta_q;
    end
  end

  // Previous HS byte, forming the 16-bit search/alignment window.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) hs_prev_q <= '0;
    else        hs_prev_q <= hs_input;
  end

  assign window_c = {hs_input, hs_prev_q};
  assign byte_c   = 8'(window_c >> offset_q);

  // Find the lowest bit offset at which the sync byte appears.
  always_comb begin
    match_c   = 1'b0;
    match_k_c = '0;
    for (int k = 7; k >= 0; k--) begin
      if (8'(window_c >> k) == SYNC_BYTE) begin
        match_c   = 1'b1;
        match_k_c = 3'(k);
      end
    end
  end

  // FSM state, counter and locked offset registers.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_DISABLED;
      cnt_q    <= '0;
      offset_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      offset_q <= offset_d;
    end
  end

  // Next-state logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    offset_d      = offset_q;
    push_c        = 1'b0;
    flush_c       = 1'b0;
    rx_eot_d      = 1'b0;
    err_sot_d     = 1'b0;
    err_control_d = 1'b0;

    unique case (state_q)
      ST_DISABLED: begin
        if (lines_enable) state_d = ST_WAIT_STOP;
      end
      ST_WAIT_STOP: begin
        if (lp_sync_q == LP_11) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (lp_sync_q == LP_01) begin
          state_d = ST_HS_RQST;
        end else if (lp_sync_q != LP_11) begin
          err_control_d = 1'b1;
          state_d       = ST_WAIT_STOP;
        end
      end
      ST_HS_RQST: begin
        if (lp_sync_q == LP_00) begin
          state_d = ST_HS_SETTLE;
          cnt_d   = '0;
        end else if (lp_sync_q == LP_11) begin
          state_d = ST_STOP;
        end else if (lp_sync_q == LP_10) begin
          err_control_d = 1'b1;
          state_d       = ST_WAIT_STOP;
        end
      end
      ST_HS_SETTLE: begin
        if (lp_sync_q == LP_00) begin
          if (cnt_q == CNT_W'(HS_SETTLE_CYCLES - 1)) begin
            state_d = ST_SYNC_SEARCH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          err_control_d = 1'b1;
          state_d       = (lp_sync_q == LP_11) ? ST_STOP : ST_WAIT_STOP;
        end
      end
      ST_SYNC_SEARCH: begin
        // LP-11 takes priority over a sync match in the same cycle.
        if (lp_sync_q == LP_11) begin
          err_sot_d = 1'b1;
          state_d   = ST_STOP;
        end else if (match_c) begin
          offset_d = match_k_c;
          state_d  = ST_HS_DATA;
        end else if (cnt_q == CNT_W'(SYNC_TIMEOUT - 1)) begin
          err_sot_d = 1'b1;
          state_d   = ST_WAIT_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HS_DATA: begin
        if (lp_sync_q == LP_11) begin
          rx_eot_d = 1'b1;
          flush_c  = 1'b1;
          state_d  = ST_STOP;
        end else begin
          push_c = 1'b1;
        end
      end
      default: state_d = ST_DISABLED;
    endcase

    // Disable overrides everything and drops any burst silently.
    if (!lines_enable) begin
      state_d       = ST_DISABLED;
      push_c        = 1'b0;
      flush_c       = 1'b1;
      rx_eot_d      = 1'b0;
      err_sot_d     = 1'b0;
      err_control_d = 1'b0;
    end

    term_d   = (state_d == ST_HS_SETTLE) || (state_d == ST_SYNC_SEARCH) ||
               (state_d == ST_HS_DATA);
    stop_d   = (state_d == ST_STOP);
    active_d = (state_d == ST_HS_DATA);
  end

  // Trailer delay line: a byte leaves only when a newer byte pushes it out.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      dl_valid_q <= '0;
      for (int i = 0; i < int'(TRAIL_BYTES); i++) dl_data_q[i] <= '0;
    end else if (flush_c) begin
      dl_valid_q <= '0;
    end else if (push_c) begin
      dl_data_q[0] <= byte_c;
      for (int i = 1; i < int'(TRAIL_BYTES); i++) dl_data_q[i] <= dl_data_q[i-1];
      dl_valid_q <= (dl_valid_q << 1) | TRAIL_BYTES'(1);
    end
  end

  assign out_valid_c = push_c && dl_valid_q[TRAIL_BYTES-1];

  // Registered outputs; sent_q marks that this burst already produced rx_sot.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      term_q        <= 1'b0;
      stop_q        <= 1'b0;
      err_sot_q     <= 1'b0;
      err_control_q <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_sot_q      <= 1'b0;
      rx_eot_q      <= 1'b0;
      rx_active_q   <= 1'b0;
      sent_q        <= 1'b0;
    end else begin
      term_q        <= term_d;
      stop_q        <= stop_d;
      err_sot_q     <= err_sot_d;
      err_control_q <= err_control_d;
      rx_data_q     <= out_valid_c ? dl_data_q[TRAIL_BYTES-1] : 8'h00;
      rx_valid_q    <= out_valid_c;
      rx_sot_q      <= out_valid_c && !sent_q;
      rx_eot_q      <= rx_eot_d;
      rx_active_q   <= active_d;
      sent_q        <= active_d && (sent_q || out_valid_c);
    end
  end

  assign hs_term_enable = term_q;
  assign stop_state     = stop_q;
  assign err_sot        = err_sot_q;
  assign err_control    = err_control_q;
  assign rx.rx_data     = rx_data_q;
  assign rx.rx_valid    = rx_valid_q;
  assign rx.rx_sot      = rx_sot_q;
  assign rx.rx_eot      = rx_eot_q;
  assign rx.rx_active   = rx_active_q;

endmodule
